freq_edge_counter: RTL and testbench
====================================

Name: freq_edge_counter

Overview:
- Measures the frequency of a slow divided clock (e.g. divideby2/4/8/16 from the counter-based clock divider) by counting its rising edges over a fixed gate window of system clock cycles.
- Sits directly downstream of the divider; its count checks the divider ratio in-system and feeds status logic.
- Input signal is generated from, and is synchronous to, clk.

Parameters:
- GATE_CYCLES, 160, length of the measurement window in clk cycles (must be >= 2).
- CNT_WIDTH, 8, width of the edge count result.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sig_in  input  1  divided signal to measure; synchronous to clk.
- start  input  1  request a measurement; sampled only in IDLE.
- busy  output  1  high from ARM through MEASURE.
- done  output  1  one-cycle pulse when count is valid.
- count  output  CNT_WIDTH  rising edges counted in the last window; holds until next ARM.
- ovf  output  1  edge total exceeded 2^CNT_WIDTH-1 in the last window.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, count=0, ovf=0; internal edge counter, gate counter and sig_in history register = 0.
- FSM states: IDLE, ARM, MEASURE, DONE.
  - IDLE -> ARM when start=1.
  - ARM -> MEASURE unconditionally after 1 cycle.
  - MEASURE -> DONE after exactly GATE_CYCLES cycles.
  - DONE -> IDLE unconditionally after 1 cycle.
- Timing: start sampled high at edge t. ARM occupies cycle t+1; MEASURE occupies t+2 .. t+1+GATE_CYCLES; DONE occupies t+2+GATE_CYCLES with done=1. Start-to-done latency is GATE_CYCLES+2 cycles.
- ARM:
  - Clears the edge counter, ovf and gate counter.
  - Loads sig_prev <= sig_in, so no spurious edge is counted on entering MEASURE.
  - count output is not cleared in ARM.
- MEASURE:
  - Every cycle: sig_prev <= sig_in.
  - A rising edge is sig_prev=0 and sig_in=1.
  - Each edge increments the edge counter.
  - The counter saturates at 2^CNT_WIDTH-1; an edge arriving at saturation sets ovf.
- DONE: count <= edge counter, ovf published; done=1 for this cycle only.
- Outputs: busy=1 in ARM and MEASURE, otherwise 0. done is high only in DONE. count and ovf are registered and stable outside DONE.
- start is ignored in ARM, MEASURE and DONE; no queuing. start held high continuously gives back-to-back measurements with one IDLE cycle between done and the next ARM.
- sig_in constant across the window -> count=0, ovf=0.
- Reset asserted mid-MEASURE -> next cycle is IDLE with all outputs at reset values; no done pulse.
- Gate counter width is clog2(GATE_CYCLES+1); it wraps only via reload in ARM.

Optional Feature:
- Macro: FREQ_EDGE_SYNC_IN_EN.
- Defined:
  - sig_in passes through a 2-flop synchronizer (reset to 0) before edge detection, for use with an asynchronous source.
  - Edge detection lags sig_in by 2 cycles; the window length is unchanged.
  - ARM loads sig_prev from the synchronizer output.
- Not defined: sig_in is used directly; no synchronizer flops exist.
- Counts for a periodic synchronous input are identical in both builds, because the window contains an integer number of periods.

Test Plan:
- Reset check: hold reset 2 cycles with start=1 -> busy=0, done=0, count=0, ovf=0; no state change until reset deasserts.
- Divide-by-8 input (period 80 ns at 10 ns clk), GATE_CYCLES=160, one start pulse -> done exactly 162 cycles after start, count=20, ovf=0, busy high for 161 cycles.
- Repeat with divide-by-2 and divide-by-16 inputs -> count=80 and count=10 respectively. Run each at two different start phases; count must not change.
- CNT_WIDTH=4 with divide-by-8 input -> count=15 (saturated), ovf=1. A following measurement with sig_in held at 0 -> count=0, ovf=0.
- start pulsed again 30 cycles into MEASURE -> ignored: single done, count=20. Then start held high -> successive done pulses 163 cycles apart.
- Reset asserted 50 cycles into MEASURE for 1 cycle -> IDLE next cycle, count=0, no done. A new start then gives count=20.

Source files
------------

// File: rtl/freq_edge_counter.sv
// Measures a slow clock-synchronous signal by counting its rising edges over a fixed gate window.
// Define FREQ_EDGE_SYNC_IN_EN to place a 2-flop synchronizer on sig_in for asynchronous sources.

// state   | meaning
// IDLE    | waiting for start
// ARM     | clear edge/gate counters, capture sig_in history
// MEASURE | count rising edges for GATE_CYCLES cycles
// DONE    | count/ovf valid, done pulses for one cycle
module freq_edge_counter #(
    parameter int GATE_CYCLES = 160,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sig_in,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 ovf
);

    localparam int GW = $clog2(GATE_CYCLES + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [GW-1:0]        gate_cnt;
    logic [CNT_WIDTH-1:0] edge_cnt;
    logic [CNT_WIDTH-1:0] edge_nxt;
    logic                 ovf_acc;
    logic                 ovf_nxt;
    logic                 sig_prev;
    logic                 sig_s;
    logic                 rise;
    logic                 sat;
    logic                 gate_last;

`ifdef FREQ_EDGE_SYNC_IN_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], sig_in};
        end
    end

    assign sig_s = sync_q[1];
`else
    assign sig_s = sig_in;
`endif

    assign rise      = ~sig_prev & sig_s;
    assign sat       = (edge_cnt == {CNT_WIDTH{1'b1}});
    assign gate_last = (gate_cnt == GW'(GATE_CYCLES - 1));

    always_comb begin
        edge_nxt = edge_cnt;
        ovf_nxt  = ovf_acc;
        if (rise) begin
            if (sat) begin
                ovf_nxt = 1'b1;
            end else begin
                edge_nxt = edge_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARM;
            ARM:     state_nxt = MEASURE;
            MEASURE: if (gate_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Results are published on the last MEASURE edge so they are already valid while done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_acc  <= 1'b0;
            sig_prev <= 1'b0;
            count    <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    ovf_acc  <= 1'b0;
                    sig_prev <= sig_s;
                end
                MEASURE: begin
                    gate_cnt <= gate_cnt + GW'(1);
                    edge_cnt <= edge_nxt;
                    ovf_acc  <= ovf_nxt;
                    sig_prev <= sig_s;
                    if (gate_last) begin
                        count <= edge_nxt;
                        ovf   <= ovf_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == ARM) || (state == MEASURE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_freq_edge_counter.sv
// Scoreboard bench for freq_edge_counter: two instances (8-bit and 4-bit count) see the same stimulus.
module tb_freq_edge_counter;

    localparam int G = 160;

    typedef struct {
        int cnt;
        int ov;
        int cyc;
    } exp_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       sig_in = 1'b0;
    logic       start  = 1'b0;
    logic       busy8, done8, ovf8;
    logic [7:0] count8;
    logic       busy4, done4, ovf4;
    logic [3:0] count4;

    always #5 clk = ~clk;

    freq_edge_counter #(.GATE_CYCLES(G), .CNT_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(start),
        .busy(busy8), .done(done8), .count(count8), .ovf(ovf8)
    );

    freq_edge_counter #(.GATE_CYCLES(G), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(start),
        .busy(busy4), .done(done4), .count(count4), .ovf(ovf4)
    );

    int   cyc = 0;
    logic rst_q = 1'b1;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    // Divided-clock model: period div_n cycles, 50% duty; div_n 0 = held low, 1 = held high.
    int ph = 0;
    int div_n = 8;
    int ph_adj = 0;

    always @(negedge clk) begin
        ph = ph + 1;
        if (div_n == 0)
            sig_in = 1'b0;
        else if (div_n == 1)
            sig_in = 1'b1;
        else
            sig_in = (((ph + ph_adj) % div_n) < (div_n / 2));
    end

    exp_t q8[$];
    exp_t q4[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;
    int   timeouts = 0;
    bit   end_req = 0;
    bit   end_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sole owner of the check/error counters.
    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            chk("rst_busy8", busy8, 0);
            chk("rst_done8", done8, 0);
            chk("rst_count8", count8, 0);
            chk("rst_ovf8", ovf8, 0);
            chk("rst_busy4", busy4, 0);
            chk("rst_done4", done4, 0);
            chk("rst_count4", count4, 0);
            chk("rst_ovf4", ovf4, 0);
            busy_run = 0;
        end else begin
            if (busy8) busy_run++;
            if (done8) begin
                chk("done8_pending", (q8.size() != 0) ? 1 : 0, 1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    chk("count8", count8, e.cnt);
                    chk("ovf8", ovf8, e.ov);
                    chk("done8_cycle", cyc, e.cyc);
                    chk("busy8_len", busy_run, G + 1);
                end
                busy_run = 0;
            end
            if (done4) begin
                chk("done4_pending", (q4.size() != 0) ? 1 : 0, 1);
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    chk("count4", count4, e.cnt);
                    chk("ovf4", ovf4, e.ov);
                    chk("done4_cycle", cyc, e.cyc);
                end
            end
        end
        if (end_req && !end_done) begin
            chk("q8_drained", q8.size(), 0);
            chk("q4_drained", q4.size(), 0);
            chk("timeouts", timeouts, 0);
            end_done = 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int edges, input int sc);
        exp_t e;
        e.cnt = edges;
        e.ov  = 0;
        e.cyc = sc + G + 2;
        q8.push_back(e);
        e.cnt = (edges > 15) ? 15 : edges;
        e.ov  = (edges > 15) ? 1 : 0;
        q4.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            timeouts++;
            $display("FAIL drain_timeout: pending %0d expected 0", q8.size());
        end
        tick(2);
    endtask

    task automatic measure(input int d, input int adj, input int edges);
        @(negedge clk);
        div_n  = d;
        ph_adj = adj;
        tick(3);
        start = 1'b1;
        push_exp(edges, cyc);
        @(negedge clk);
        start = 1'b0;
        wait_drain();
    endtask

    initial begin
        int n;
        // Reset held two cycles with start asserted.
        reset = 1'b1;
        start = 1'b1;
        tick(2);
        reset = 1'b0;
        start = 1'b0;
        tick(3);

        measure(8, 0, 20);
        measure(8, 3, 20);
        measure(0, 0, 0);
        measure(2, 0, 80);
        measure(2, 1, 80);
        measure(16, 0, 10);
        measure(16, 5, 10);
        measure(1, 0, 0);

        // Second start 30 cycles into MEASURE is ignored.
        div_n = 8;
        tick(3);
        start = 1'b1;
        push_exp(20, cyc);
        @(negedge clk);
        start = 1'b0;
        tick(31);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        tick(G + 10);

        // start held high: back-to-back runs G+3 cycles apart.
        start = 1'b1;
        push_exp(20, cyc);
        push_exp(20, cyc + (G + 3));
        push_exp(20, cyc + 2 * (G + 3));
        n = 0;
        while (q8.size() > 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            timeouts++;
            $display("FAIL hold_timeout: pending %0d expected 1", q8.size());
        end
        tick(10);
        start = 1'b0;
        wait_drain();
        tick(G + 10);

        // Reset 50 cycles into MEASURE: no done, outputs back to reset values.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick(51);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick(G + 10);
        measure(8, 2, 20);

        end_req = 1;
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
